// File: rtl/mem_io_pkg.sv
// Shared address-map defaults, port count and FSM encoding for the data-memory/I/O responder.
package mem_io_pkg;

  localparam int unsigned NUM_PORTS      = 4;
  localparam int unsigned PORT_IDX_W     = 2;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_RAM_WORDS  = 240;
  localparam int unsigned DEF_OUT_BASE   = 32'h0000_00F0;
  localparam int unsigned DEF_IN_BASE    = 32'h0000_00F4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/io_in_sync.sv
// Two-flop synchronizer for one asynchronous input port; q is the second stage.
module io_in_sync #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/data_mem_io.sv
// Data RAM, output port registers and synchronized input ports behind the CPU's
// single-cycle read/write strobes, with a sticky fault recorder.
module data_mem_io
  import mem_io_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAM_WORDS = DEF_RAM_WORDS,
  parameter int unsigned OUT_BASE  = DEF_OUT_BASE,
  parameter int unsigned IN_BASE   = DEF_IN_BASE
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        read,
  input  logic                        write,
  input  logic                        halted,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS*DATA_W-1:0] io_out,
  output logic [NUM_PORTS-1:0]        io_out_stb,
  input  logic [NUM_PORTS*DATA_W-1:0] io_in,
  output logic [NUM_PORTS-1:0]        io_in_stb,
  output logic                        err,
  output logic [ADDR_W-1:0]           err_addr
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  state_e state_q, state_d;
  logic                        err_q, err_d;
  logic [ADDR_W-1:0]           err_addr_q, err_addr_d;
  logic [NUM_PORTS*DATA_W-1:0] io_out_q, io_out_d;
  logic [NUM_PORTS-1:0]        out_stb_q, out_stb_d;
  logic [NUM_PORTS-1:0]        in_stb_q, in_stb_d;
  logic [DATA_W-1:0]           ram_q [RAM_WORDS];

  logic [DATA_W-1:0]     in_sync_w [NUM_PORTS];
  logic [ADDR_W-1:0]     out_off_c, in_off_c;
  logic [PORT_IDX_W-1:0] out_idx_c, in_idx_c;
  logic is_ram_c, is_out_c, is_in_c, access_c, fault_c, wr_ok_c, rd_ok_c;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_sync
    io_in_sync #(.W(DATA_W)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (io_in[g*DATA_W +: DATA_W]),
      .q       (in_sync_w[g])
    );
  end

  // Address decode; offsets wrap below the base so one compare covers both bounds.
  always_comb begin
    out_off_c = addr - ADDR_W'(OUT_BASE);
    in_off_c  = addr - ADDR_W'(IN_BASE);
    out_idx_c = out_off_c[PORT_IDX_W-1:0];
    in_idx_c  = in_off_c[PORT_IDX_W-1:0];
    is_ram_c  = 32'(addr) < RAM_WORDS;
    is_out_c  = !is_ram_c && (out_off_c < ADDR_W'(NUM_PORTS));
    is_in_c   = !is_ram_c && !is_out_c && (in_off_c < ADDR_W'(NUM_PORTS));
    access_c  = !halted && (read || write);
    fault_c   = access_c && ((read && write) || (write && is_in_c) ||
                             !(is_ram_c || is_out_c || is_in_c));
    wr_ok_c   = access_c && write && !fault_c;
    rd_ok_c   = access_c && read && !fault_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && fault_c) state_d = ST_FAULT;
  end

  // Only the first fault is latched; RAM/OUT writes keep working in FAULT.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    io_out_d   = io_out_q;
    out_stb_d  = '0;
    in_stb_d   = '0;
    if (state_q == ST_RUN && fault_c) begin
      err_d      = 1'b1;
      err_addr_d = addr;
    end
    if (wr_ok_c && is_out_c) begin
      io_out_d[int'(out_idx_c)*DATA_W +: DATA_W] = wdata;
      out_stb_d[out_idx_c] = 1'b1;
    end
    if (rd_ok_c && is_in_c) in_stb_d[in_idx_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
      io_out_q   <= '0;
      out_stb_q  <= '0;
      in_stb_q   <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      io_out_q   <= io_out_d;
      out_stb_q  <= out_stb_d;
      in_stb_q   <= in_stb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c && is_ram_c) ram_q[addr[RAM_AW-1:0]] <= wdata;
  end

  // Zero-latency read mux; idle, halted and faulting reads return zero.
  always_comb begin
    rdata = '0;
    if (rd_ok_c) begin
      if (is_ram_c)      rdata = ram_q[addr[RAM_AW-1:0]];
      else if (is_out_c) rdata = io_out_q[int'(out_idx_c)*DATA_W +: DATA_W];
      else               rdata = in_sync_w[in_idx_c];
    end
  end

  assign io_out     = io_out_q;
  assign io_out_stb = out_stb_q;
  assign io_in_stb  = in_stb_q;
  assign err        = err_q;
  assign err_addr   = err_addr_q;

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-memory and I/O responder on the far end of the multicycle CPU's memory interface. It answers the control unit's single-cycle `read`/`write` strobes issued in the RMEM and WMEM states. Behind an 8-bit address it decodes a word RAM, four output port registers and four synchronized input ports. Protocol violations are recorded in a sticky error state.

## Interface
- `DATA_W`, default 8: data word width.
- `ADDR_W`, default 8: address width.
- `RAM_WORDS`, default 240: RAM occupies addresses 0x00..RAM_WORDS-1.
- `OUT_BASE`, default 8'hF0: output ports occupy OUT_BASE..OUT_BASE+3.
- `IN_BASE`, default 8'hF4: input ports occupy IN_BASE..IN_BASE+3.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  reset; one clock, asynchronous and active-low.
- `addr`  in  ADDR_W  access address, valid while `read` or `write` is high.
- `wdata`  in  DATA_W  write data, valid with `write`.
- `read`  in  1  read strobe, one cycle per access.
- `write`  in  1  write strobe, one cycle per access.
- `halted`  in  1  CPU halted; suppresses all accesses.
- `rdata`  out  DATA_W  combinational read data.
- `io_out`  out  4*DATA_W  output port registers, port k at bits [k*DATA_W +: DATA_W].
- `io_out_stb`  out  4  one-cycle pulse per output port after it is written.
- `io_in`  in  4*DATA_W  asynchronous external input ports.
- `io_in_stb`  out  4  one-cycle pulse per input port after it is read (consume ack).
- `err`  out  1  sticky error flag.
- `err_addr`  out  ADDR_W  address of the first faulting access.

## Operation
- Address decode:
  - RAM: addr < RAM_WORDS.
  - OUT: OUT_BASE..+3, read/write.
  - IN: IN_BASE..+3, read-only.
  - Anything else is unmapped.
- FSM states:
  - RUN: normal operation.
  - FAULT: entered from RUN on the first fault. Left only by reset.
- Faults, each detected only when `halted`=0:
  - `read` and `write` high together.
  - Write to an IN address.
  - Any access to an unmapped address.
- Faulting access is not performed. `err`<=1 and `err_addr`<=addr on that edge.
- In FAULT, RAM and OUT writes still execute normally. `err_addr` holds the first faulting address.
- Write, `halted`=0 and no fault:
  - RAM: word updated on the edge.
  - OUT: port k register updated on the edge.
- Read, `halted`=0 and no fault, `rdata` during the same cycle:
  - RAM: RAM[addr], asynchronous read.
  - OUT: current `io_out` port value.
  - IN: synchronized input value.
- `rdata` = 0 when `read`=0, when `halted`=1, and on a faulting read.
- `halted`=1: all strobes ignored. No state changes except synchronizer shifting.
- Input sync: each `io_in` port passes through two flops; reads see the second stage.

## Timing
- Reset values:
  - `io_out` = 0, `io_out_stb` = 0, `io_in_stb` = 0.
  - `err` = 0, `err_addr` = 0, synchronizer flops = 0.
  - FSM = RUN.
  - RAM contents are not reset (undefined).
- Read latency is 0 cycles. `rdata` is valid in the cycle `read` is high, so the CPU's `we_rmem` captures it at that edge.
- Write takes effect at the edge ending the `write` cycle. A read of the same location in the next cycle returns the new value.
- `io_out_stb[k]` is high exactly the cycle after the edge that wrote port k. Back-to-back writes to port k keep it high for consecutive cycles.
- `io_in_stb[k]` is high exactly the cycle after the edge ending a read of IN port k.
- An `io_in` change becomes visible to reads after 2 rising edges.
- `err` rises in the cycle after the faulting edge.
- Reset mid-operation: all registers clear immediately (asynchronously), and any pending strobe pulse is killed.

## Structure
- `mem_io_pkg` holds:
  - Address-map constants (OUT_BASE, IN_BASE, RAM_WORDS defaults).
  - Port count (4).
  - FSM state encoding (RUN, FAULT).
- One sub-module `io_in_sync`: a parameterised 2-flop synchronizer for one DATA_W port, instantiated 4 times.
- RAM is an inferred array inside `data_mem_io`.

## Test plan
- Reset: hold `reset_n`=0, release. Expect:
  - `io_out`=0, all strobes 0, `err`=0, `err_addr`=0.
  - `rdata`=0 with `read` low.
- RAM round trip: write 8'hA5 to 0x10, read 0x10 next cycle. Expect `rdata`=8'hA5 in the read cycle. Then read 0xEF after writing 8'h3C there; expect 8'h3C.
- Output port: write 8'h7E to 0xF2.
  - Expect `io_out[2]`=8'h7E from the next cycle.
  - `io_out_stb`=4'b0100 for exactly one cycle.
  - A read of 0xF2 returns 8'h7E.
- Input port: drive `io_in[1]`=8'h55, wait 2 edges, read 0xF5. Expect `rdata`=8'h55, then `io_in_stb`=4'b0010 for one cycle. A read before 2 edges returns the old value.
- Faults:
  - Write to 0xF8 (unmapped). Expect `err`=1, `err_addr`=8'hF8, no port or RAM change.
  - Then write to 0xF4 (IN port). Expect `err_addr` to stay 8'hF8.
  - Then `read`=`write`=1 together. Expect no access performed.
- Halted: with `halted`=1, write 8'h11 to 0x20 and to 0xF0. Expect:
  - RAM[0x20] unchanged, `io_out[0]` unchanged, no strobes, `err` unchanged.
  - Apply `reset_n` low mid-burst: expect all outputs back to reset values.
